// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the KEY debouncer.
// Optional glitch statistics are enabled with BUTTON_DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_t;

  localparam int unsigned DEB_SYNC_STAGES_DEF = 32'd2;
  localparam int unsigned DEB_CYCLES_DEF      = 32'd500000;
  localparam int unsigned DEB_GLITCH_W        = 32'd8;

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle between the pad stimulus and the debouncer.
// glitch_cnt_o exists only when BUTTON_DEBOUNCE_GLITCH_CNT_EN is defined.
interface button_debouncer_if;
  import debounce_pkg::*;

  logic button_raw_i;
  logic button_o;
  logic busy_o;
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
  logic [DEB_GLITCH_W-1:0] glitch_cnt_o;

  modport master (output button_raw_i, input button_o, input busy_o, input glitch_cnt_o);
  modport slave  (input button_raw_i, output button_o, output busy_o, output glitch_cnt_o);
`else
  modport master (output button_raw_i, input button_o, input busy_o);
  modport slave  (input button_raw_i, output button_o, output busy_o);
`endif

endinterface

// File: rtl/button_debouncer_sync.sv
// Multi-flop synchronizer bringing the asynchronous pad level into clk_i.
module button_synchronizer
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = DEB_SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], async_i};

  // shift chain, cleared to the released level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw KEY pin into a registered, glitch-free pressed level.
// Define BUTTON_DEBOUNCE_GLITCH_CNT_EN to add a saturating rejected-glitch counter.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEB_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  button_debouncer_if.slave bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic       norm_s;
  logic       sync_s;
  deb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       button_q, button_d;
  logic       busy_q, busy_d;

  assign norm_s = bus.button_raw_i ^ ACTIVE_LOW;

  button_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(norm_s),
    .sync_o (sync_s)
  );

  // state, qualification counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      button_q <= button_d;
      busy_q   <= busy_d;
    end
  end

  // any opposite-level sample during a WAIT drops back and restarts from zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LOW: begin
        if (sync_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end else begin
          state_d = STABLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!sync_s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync_s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end else begin
          state_d = STABLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (sync_s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs follow the settled state one register later
  always_comb begin
    button_d = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      STABLE_LOW:  begin button_d = 1'b0; busy_d = 1'b0; end
      WAIT_HIGH:   begin button_d = 1'b0; busy_d = 1'b1; end
      STABLE_HIGH: begin button_d = 1'b1; busy_d = 1'b0; end
      WAIT_LOW:    begin button_d = 1'b1; busy_d = 1'b1; end
      default:     begin button_d = 1'b0; busy_d = 1'b0; end
    endcase
  end

  assign bus.button_o = button_q;
  assign bus.busy_o   = busy_q;

`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
  logic                    reject_s;
  logic [DEB_GLITCH_W-1:0] glitch_q, glitch_d;

  assign reject_s = ((state_q == WAIT_HIGH) && !sync_s) || ((state_q == WAIT_LOW) && sync_s);

  // saturating count of rejected glitches
  always_comb begin
    if (reject_s && (glitch_q != {DEB_GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + DEB_GLITCH_W'(1);
    end else begin
      glitch_d = glitch_q;
    end
  end

  // glitch counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign bus.glitch_cnt_o = glitch_q;
`else
  // build without glitch statistics
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int S = 2;
  localparam int D = 4;
  localparam bit AL = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  button_debouncer_if bus();

  button_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: the synchronised level must differ from the accepted level for
  // D+1 consecutive samples to flip; any shorter run is a rejected glitch.
  logic [S-1:0] m_line;
  logic m_lvl, m_btn, m_busy;
  int   m_run;
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
  int   m_glitch;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_line <= '0; m_lvl <= 1'b0; m_run <= 0; m_btn <= 1'b0; m_busy <= 1'b0;
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
      m_glitch <= 0;
`endif
    end else begin
      m_btn  <= m_lvl;
      m_busy <= (m_run != 0);
      m_line <= {m_line[S-2:0], bus.button_raw_i ^ AL};
      if (m_line[S-1] != m_lvl) begin
        if (m_run == D) begin
          m_lvl <= ~m_lvl;
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        if (m_run != 0 && m_glitch < 255) m_glitch <= m_glitch + 1;
`endif
        m_run <= 0;
      end
    end
  end

  task automatic do_reset(input logic raw_level);
    @(negedge clk);
    bus.button_raw_i = raw_level;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int rise;
    bus.button_raw_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.button_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL reset_state button=%b busy=%b required 0 0", bus.button_o, bus.busy_o);
    if (bus.button_o !== 1'b0 || bus.busy_o !== 1'b0) failures++;
    rst_n = 1'b1;
    rise = -1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      checks++;
      if (bus.button_o !== m_btn || bus.busy_o !== m_busy) begin
        failures++;
        $display("FAIL reset_release_model edge=%0d button=%b busy=%b required %b %b", e, bus.button_o, bus.busy_o, m_btn, m_busy);
      end
      if (rise < 0 && bus.button_o === 1'b1) rise = e;
    end
    checks++;
    if (rise !== 7) begin
      failures++;
      $display("FAIL reset_release_latency edge=%0d required 7", rise);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.button_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL async_clear button=%b busy=%b required 0 0", bus.button_o, bus.busy_o);
    end
  endtask

  task automatic test_clean_press();
    int rise, fall, busy_hi;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    bus.button_raw_i = 1'b0;
    rise = -1; busy_hi = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      checks++;
      if (bus.button_o !== m_btn || bus.busy_o !== m_busy) begin
        failures++;
        $display("FAIL press_model edge=%0d button=%b busy=%b required %b %b", e, bus.button_o, bus.busy_o, m_btn, m_busy);
      end
      if (rise < 0 && bus.button_o === 1'b1) rise = e;
      if (bus.busy_o === 1'b1) busy_hi++;
    end
    checks++;
    if (rise !== 7 || busy_hi !== D) begin
      failures++;
      $display("FAIL press_latency rise=%0d busy_cycles=%0d required 7 %0d", rise, busy_hi, D);
    end
    bus.button_raw_i = 1'b1;
    fall = -1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      checks++;
      if (bus.button_o !== m_btn || bus.busy_o !== m_busy) begin
        failures++;
        $display("FAIL release_model edge=%0d button=%b busy=%b required %b %b", e, bus.button_o, bus.busy_o, m_btn, m_busy);
      end
      if (fall < 0 && bus.button_o === 1'b0) fall = e;
    end
    checks++;
    if (fall !== 7) begin
      failures++;
      $display("FAIL release_latency edge=%0d required 7", fall);
    end
  endtask

  task automatic test_glitch();
    int ever;
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    ever = 0;
    for (int p = 1; p <= 3; p++) begin
      for (int c = 0; c < p + 10; c++) begin
        bus.button_raw_i = (c < p) ? 1'b0 : 1'b1;
        @(negedge clk);
        checks++;
        if (bus.button_o !== m_btn || bus.busy_o !== m_busy) begin
          failures++;
          $display("FAIL glitch_model p=%0d c=%0d button=%b busy=%b required %b %b", p, c, bus.button_o, bus.busy_o, m_btn, m_busy);
        end
        if (bus.button_o === 1'b1) ever = 1;
      end
    end
    checks++;
    if (ever != 0) begin
      failures++;
      $display("FAIL glitch_button_rose seen=%0d required 0", ever);
    end
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (bus.glitch_cnt_o !== 8'd3) begin
      failures++;
      $display("FAIL glitch_count got=%0d required 3", bus.glitch_cnt_o);
    end
`endif
  endtask

  task automatic test_bounce();
    int rises, rise_at;
    logic prev;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    rises = 0; rise_at = -1; prev = bus.button_o;
    for (int t = 0; t < 12; t++) begin
      bus.button_raw_i = (((t / 2) % 2) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.button_o === 1'b1 && prev === 1'b0) rises++;
      prev = bus.button_o;
    end
    bus.button_raw_i = 1'b0;
    for (int e = 0; e < 15; e++) begin
      @(negedge clk);
      checks++;
      if (bus.button_o !== m_btn) begin
        failures++;
        $display("FAIL bounce_model edge=%0d button=%b required %b", e, bus.button_o, m_btn);
      end
      if (bus.button_o === 1'b1 && prev === 1'b0) begin
        rises++;
        rise_at = e;
      end
      prev = bus.button_o;
    end
    checks++;
    if (rises !== 1 || rise_at !== 7) begin
      failures++;
      $display("FAIL bounce_single_rise rises=%0d edge=%0d required 1 7", rises, rise_at);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rise;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    bus.button_raw_i = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.button_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_busy busy=%b button=%b required 1 0", bus.busy_o, bus.button_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.button_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_async busy=%b button=%b required 0 0", bus.busy_o, bus.button_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rise = -1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (rise < 0 && bus.button_o === 1'b1) rise = e;
    end
    checks++;
    if (rise !== 7) begin
      failures++;
      $display("FAIL mid_wait_requalify edge=%0d required 7", rise);
    end
  endtask

  task automatic test_random();
    int len;
    do_reset(1'b1);
    for (int seg = 0; seg < 60; seg++) begin
      bus.button_raw_i = 1'($urandom_range(1, 0));
      len = int'($urandom_range(8, 1));
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        checks++;
        if (bus.button_o !== m_btn || bus.busy_o !== m_busy) begin
          failures++;
          $display("FAIL random_model seg=%0d button=%b busy=%b required %b %b", seg, bus.button_o, bus.busy_o, m_btn, m_busy);
        end
      end
    end
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (int'(bus.glitch_cnt_o) !== m_glitch) begin
      failures++;
      $display("FAIL random_glitch_count got=%0d required %0d", bus.glitch_cnt_o, m_glitch);
    end
`endif
  endtask

`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
  task automatic test_saturation();
    int ever;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    ever = 0;
    for (int g = 0; g < 300; g++) begin
      bus.button_raw_i = 1'b0;
      @(negedge clk);
      bus.button_raw_i = 1'b1;
      repeat (2) @(negedge clk);
      if (bus.button_o === 1'b1) ever = 1;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.glitch_cnt_o !== 8'd255 || ever != 0) begin
      failures++;
      $display("FAIL glitch_saturation count=%0d rose=%0d required 255 0", bus.glitch_cnt_o, ever);
    end
  endtask
`endif

  initial begin
    bus.button_raw_i = 1'b1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_reset_mid_wait();
    test_random();
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
